framebuffer_scanout: RTL



---
 rtl/video_pkg.sv | 38 +++
 rtl/framebuffer_scanout_if.sv | 32 +++
 rtl/video_timing_gen.sv | 78 +++++++
 rtl/framebuffer_scanout.sv | 125 ++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video types and default 640x480@60 timing.
// Used by both the framebuffer writer and scanout.
package video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // One raster position's control bits as they travel
  // alongside the framebuffer read.
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic first;
  } tap_t;

  localparam tap_t TAP_IDLE = '{
    vis: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0
  };

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port plus the re-timed video output.
// master = scanout side, slave = framebuffer/display side.
interface framebuffer_scanout_if
  import video_pkg::*;
#(
  parameter int ADDR_W = 19
);
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_addr;
  rgb_t              fb_rdata;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              hsync;
  logic              vsync;
  logic              video_active;
  logic              frame_start;

  modport master (
    output fb_rd_en, fb_addr,
    input  fb_rdata,
    output red, green, blue,
    output hsync, vsync, video_active, frame_start
  );

  modport slave (
    input  fb_rd_en, fb_addr,
    output fb_rdata,
    input  red, green, blue,
    input  hsync, vsync, video_active, frame_start
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster counters and stage-0 visible/sync flags.
// Advances one position per pix_en tick.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  output tap_t tap,
  output logic frame_wrap
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END =
    HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END =
    VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          h_end, v_end;

  // Next raster position: wrap h at line end, v at frame end.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    h_end    = (hcount_q == H_LAST);
    v_end    = (vcount_q == V_LAST);
    if (pix_en) begin
      if (h_end) begin
        hcount_d = '0;
        vcount_d = v_end ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // Stage-0 flags decoded from the current position.
  always_comb begin
    tap.vis   = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    tap.hs    = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
    tap.vs    = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
    tap.first = (hcount_q == '0) && (vcount_q == '0);
    frame_wrap = pix_en && h_end && v_end;
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// Raster-order framebuffer reader; re-aligns read data
// with VGA syncs across the framebuffer read latency.
module framebuffer_scanout
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int ADDR_W     = 19,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic pix_en,
  framebuffer_scanout_if.master bus
);

  tap_t s0;
  logic frame_wrap;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .tap        (s0),
    .frame_wrap (frame_wrap)
  );

  logic [ADDR_W-1:0] addr_q, addr_d;
  tap_t pipe_q [RD_LATENCY];
  tap_t pipe_d [RD_LATENCY];
  tap_t tail;
  rgb_t rgb_q, rgb_d;
  logic act_q, act_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic fs_q, fs_d;

  // Address walks visible pixels only; restarts each frame.
  always_comb begin
    addr_d = addr_q;
    if (frame_wrap) begin
      addr_d = '0;
    end else if (pix_en && s0.vis) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Control taps shift in step with the read pipeline.
  always_comb begin
    pipe_d = pipe_q;
    if (pix_en) begin
      pipe_d[0] = s0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  assign tail = pipe_q[RD_LATENCY-1];

  // Output stage: capture read data beside its own syncs.
  always_comb begin
    rgb_d = rgb_q;
    act_d = act_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = 1'b0;
    if (pix_en) begin
      rgb_d = tail.vis ? bus.fb_rdata : '0;
      act_d = tail.vis;
      hs_d  = tail.hs;
      vs_d  = tail.vs;
      fs_d  = tail.first;
    end
  end

  // All scanout state.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= TAP_IDLE;
      end
      rgb_q <= '0;
      act_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      pipe_q <= pipe_d;
      rgb_q  <= rgb_d;
      act_q  <= act_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
    end
  end

  assign bus.fb_rd_en     = pix_en && !reset;
  assign bus.fb_addr      = addr_q;
  assign bus.red          = rgb_q.r;
  assign bus.green        = rgb_q.g;
  assign bus.blue         = rgb_q.b;
  assign bus.video_active = act_q;
  assign bus.hsync        = hs_q;
  assign bus.vsync        = vs_q;
  assign bus.frame_start  = fs_q;

endmodule
